// File: rtl/joy_split_demux.sv
// DB9 splitter scan front-end: drives JOY_SEL, synchronises and debounces the shared
// joystick bus per side, and merges active-low keyboard overrides into two player ports.
module joy_split_demux #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE      = 3,
  parameter int JOY_W         = 6
) (
  input  logic             PCLK,
  input  logic             I_RESET_N,
  input  logic [JOY_W-1:0] JOYSTICK,
  input  logic [JOY_W-1:0] KEY_JOY_A,
  input  logic [JOY_W-1:0] KEY_JOY_B,
  input  logic             SPLIT_EN,
  output logic             JOY_SEL,
  output logic [JOY_W-1:0] JOY_A,
  output logic [JOY_W-1:0] JOY_B,
  output logic             VALID
);

  typedef enum logic [1:0] {SETTLE_A, SAMPLE_A, SETTLE_B, SAMPLE_B} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB_N       = 4'(DEBOUNCE);

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic                  w_sel_nxt, w_valid_nxt;
  logic [JOY_W-1:0]      r_sync1, r_sync2;
  logic [JOY_W-1:0]      r_deb_a, r_deb_b;
  logic [JOY_W-1:0][3:0] r_cnt_a, r_cnt_b;

  // One debounce step for a single bit: returns {new debounced bit, new run counter}.
  function automatic logic [4:0] deb_step(input logic smp, input logic deb,
                                          input logic [3:0] cnt);
    if (smp == deb)
      return {deb, 4'd0};
    else if (cnt + 4'd1 == DEB_N)
      return {~deb, 4'd0};
    else
      return {deb, cnt + 4'd1};
  endfunction

  always_ff @(posedge PCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= JOYSTICK;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge PCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_state <= SETTLE_A;
      r_cnt   <= '0;
      JOY_SEL <= 1'b0;
      VALID   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      JOY_SEL <= w_sel_nxt;
      VALID   <= w_valid_nxt;
    end
  end

  // JOY_SEL only moves on the edge into a settle state, so each side settles fully.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = JOY_SEL;
    w_valid_nxt = 1'b0;
    unique case (r_state)
      SETTLE_A: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = SAMPLE_A;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      SAMPLE_A: begin
        if (SPLIT_EN) begin
          w_state_nxt = SETTLE_B;
          w_sel_nxt   = 1'b1;
        end else begin
          w_state_nxt = SETTLE_A;
          w_sel_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
        end
      end
      SETTLE_B: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = SAMPLE_B;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      SAMPLE_B: begin
        w_state_nxt = SETTLE_A;
        w_sel_nxt   = 1'b0;
        w_valid_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_deb_a <= '1;
      r_cnt_a <= '0;
    end else if (r_state == SAMPLE_A) begin
      for (int i = 0; i < JOY_W; i++)
        {r_deb_a[i], r_cnt_a[i]} <= deb_step(r_sync2[i], r_deb_a[i], r_cnt_a[i]);
    end
  end

  // Dropping out of split mode parks side B at idle so JOY_B reduces to the key inputs.
  always_ff @(posedge PCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_deb_b <= '1;
      r_cnt_b <= '0;
    end else if (r_state == SAMPLE_A && !SPLIT_EN) begin
      r_deb_b <= '1;
      r_cnt_b <= '0;
    end else if (r_state == SAMPLE_B) begin
      for (int i = 0; i < JOY_W; i++)
        {r_deb_b[i], r_cnt_b[i]} <= deb_step(r_sync2[i], r_deb_b[i], r_cnt_b[i]);
    end
  end

  always_ff @(posedge PCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      JOY_A <= '1;
      JOY_B <= '1;
    end else begin
      JOY_A <= r_deb_a & KEY_JOY_A;
      JOY_B <= r_deb_b & KEY_JOY_B;
    end
  end

endmodule

// File: tb/tb_joy_split_demux.sv
// Randomised scan-frame bench for joy_split_demux: a splitter model drives the shared bus,
// a frame-level debounce model predicts each frame's outputs, and a monitor scores them on VALID.
module tb_joy_split_demux;

  localparam int S  = 4;
  localparam int DB = 3;
  localparam int W  = 6;
  localparam int FLEN_SPLIT  = 2 * (S + 1);
  localparam int FLEN_SINGLE = S + 1;

  logic         PCLK = 1'b0;
  logic         I_RESET_N;
  logic [W-1:0] JOYSTICK, KEY_JOY_A, KEY_JOY_B;
  logic [W-1:0] side_a, side_b;
  logic         SPLIT_EN;
  logic         JOY_SEL, VALID;
  logic [W-1:0] JOY_A, JOY_B;

  always #5 PCLK = ~PCLK;

  // Splitter: the select line routes one physical joystick onto the shared bus.
  assign JOYSTICK = JOY_SEL ? side_b : side_a;

  joy_split_demux #(.SETTLE_CYCLES(S), .DEBOUNCE(DB), .JOY_W(W)) dut (
    .PCLK(PCLK), .I_RESET_N(I_RESET_N), .JOYSTICK(JOYSTICK),
    .KEY_JOY_A(KEY_JOY_A), .KEY_JOY_B(KEY_JOY_B), .SPLIT_EN(SPLIT_EN),
    .JOY_SEL(JOY_SEL), .JOY_A(JOY_A), .JOY_B(JOY_B), .VALID(VALID)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           len;
    int           selc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b1;

  // Frame-level model: debounced value per bit and length of the current disagreeing run.
  logic [W-1:0] m_deb_a, m_deb_b;
  int           m_run_a[W];
  int           m_run_b[W];

  logic [W-1:0] ra, rb, rka, rkb, kold;
  bit           rsp;
  int           mk, msel;
  bit           mpend;
  exp_t         me;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_deb_a = '1;
    m_deb_b = '1;
    for (int i = 0; i < W; i++) begin
      m_run_a[i] = 0;
      m_run_b[i] = 0;
    end
  endtask

  task automatic model_sample(input bit is_b, input logic [W-1:0] smp);
    for (int i = 0; i < W; i++) begin
      logic cur;
      int   run;
      cur = is_b ? m_deb_b[i] : m_deb_a[i];
      run = is_b ? m_run_b[i] : m_run_a[i];
      if (smp[i] == cur) begin
        run = 0;
      end else begin
        run = run + 1;
        if (run == DB) begin
          cur = ~cur;
          run = 0;
        end
      end
      if (is_b) begin
        m_deb_b[i] = cur;
        m_run_b[i] = run;
      end else begin
        m_deb_a[i] = cur;
        m_run_a[i] = run;
      end
    end
  endtask

  task automatic apply_frame(input bit sp, input logic [W-1:0] sa, input logic [W-1:0] sb,
                             input logic [W-1:0] ka, input logic [W-1:0] kb);
    exp_t e;
    SPLIT_EN  = sp;
    side_a    = sa;
    side_b    = sb;
    KEY_JOY_A = ka;
    KEY_JOY_B = kb;
    model_sample(1'b0, sa);
    if (sp) begin
      model_sample(1'b1, sb);
    end else begin
      m_deb_b = '1;
      for (int i = 0; i < W; i++) m_run_b[i] = 0;
    end
    e.a    = m_deb_a & ka;
    e.b    = m_deb_b & kb;
    e.len  = sp ? FLEN_SPLIT : FLEN_SINGLE;
    e.selc = sp ? (S + 1) : 0;
    q.push_back(e);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(posedge PCLK);
      #1;
      n++;
    end while (!VALID && n < 40);
    if (!VALID) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout no VALID within %0d cycles at %0t", n, $time);
    end
  endtask

  task automatic next_frame(input bit sp, input logic [W-1:0] sa, input logic [W-1:0] sb,
                            input logic [W-1:0] ka, input logic [W-1:0] kb);
    wait_valid();
    @(posedge PCLK);
    #1;
    apply_frame(sp, sa, sb, ka, kb);
  endtask

  // Monitor: on VALID check frame length and select duty; one cycle later check the ports.
  initial begin
    mk = 0;
    msel = 0;
    mpend = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!I_RESET_N) begin
        mk = 0;
        msel = 0;
        mpend = 1'b0;
      end else begin
        mk++;
        if (JOY_SEL) msel++;
        if (mpend) begin
          mpend = 1'b0;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty no expected frame at %0t", $time);
          end else begin
            me = q.pop_front();
            chk("joy_a", 32'(JOY_A), 32'(me.a));
            chk("joy_b", 32'(JOY_B), 32'(me.b));
          end
        end
        if (VALID && sb_en) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty unexpected VALID at %0t", $time);
          end else begin
            chk("frame_len", 32'(mk), 32'(q[0].len));
            chk("sel_cycles", 32'(msel), 32'(q[0].selc));
            mpend = 1'b1;
          end
        end
        if (VALID) begin
          mk = 0;
          msel = 0;
        end
      end
    end
  end

  initial begin
    I_RESET_N = 1'b0;
    SPLIT_EN  = 1'b1;
    side_a    = '1;
    side_b    = '1;
    KEY_JOY_A = '1;
    KEY_JOY_B = '1;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_sel", 32'(JOY_SEL), 32'd0);
    chk("rst_a", 32'(JOY_A), 32'h3F);
    chk("rst_b", 32'(JOY_B), 32'h3F);
    chk("rst_valid", 32'(VALID), 32'd0);

    apply_frame(1'b1, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    @(negedge PCLK);
    #2;
    I_RESET_N = 1'b1;

    // Directed frames: split demux, glitch rejection, single mode, key AND.
    repeat (3) next_frame(1'b1, 6'h3E, 6'h37, 6'h3F, 6'h3F);
    repeat (3) next_frame(1'b1, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    repeat (2) next_frame(1'b1, 6'h3E, 6'h3F, 6'h3F, 6'h3F);
    next_frame(1'b1, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    repeat (4) next_frame(1'b0, 6'h3B, 6'h3F, 6'h3F, 6'h1F);
    next_frame(1'b1, 6'h3F, 6'h3F, 6'h2F, 6'h3F);
    repeat (3) next_frame(1'b1, 6'h3E, 6'h3F, 6'h2F, 6'h3F);

    ra = '1;
    rb = '1;
    for (int f = 0; f < 40; f++) begin
      rsp = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) ra = W'($urandom);
      if ($urandom_range(0, 2) == 0) rb = W'($urandom);
      rka = '1;
      rkb = '1;
      if ($urandom_range(0, 3) == 0) rka[$urandom_range(0, W - 1)] = 1'b0;
      if ($urandom_range(0, 3) == 0) rkb[$urandom_range(0, W - 1)] = 1'b0;
      next_frame(rsp, ra, rb, rka, rkb);
    end
    wait_valid();

    for (int n = 0; n < 6 && q.size() != 0; n++) begin
      @(negedge PCLK);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain %0d frames unchecked", q.size());
    end
    sb_en = 1'b0;

    // Keep samples equal to the debounced state so only the keys move the outputs.
    side_a = m_deb_a;
    side_b = m_deb_b;
    @(posedge PCLK);
    #1;
    kold = KEY_JOY_A;
    KEY_JOY_A = 6'h2F;
    @(negedge PCLK);
    chk("key_before_edge", 32'(JOY_A), 32'(m_deb_a & kold));
    @(posedge PCLK);
    #1;
    chk("key_1cyc", 32'(JOY_A), 32'(m_deb_a & 6'h2F));

    // Asynchronous reset in the middle of the side-B settle window.
    KEY_JOY_A = 6'h3E;
    SPLIT_EN  = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(posedge PCLK);
        #1;
        n++;
      end while (!JOY_SEL && n < 30);
      if (!JOY_SEL) begin
        checks++;
        errors++;
        $display("FAIL sel_timeout JOY_SEL never rose");
      end
    end
    @(posedge PCLK);
    #2;
    chk("pre_rst_a_bit0", 32'(JOY_A[0]), 32'd0);
    I_RESET_N = 1'b0;
    #1;
    chk("async_rst_a", 32'(JOY_A), 32'h3F);
    chk("async_rst_b", 32'(JOY_B), 32'h3F);
    chk("async_rst_sel", 32'(JOY_SEL), 32'd0);
    chk("async_rst_valid", 32'(VALID), 32'd0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    #2;
    I_RESET_N = 1'b1;
    for (int k = 1; k <= FLEN_SPLIT; k++) begin
      @(negedge PCLK);
      chk("valid_after_rst", 32'(VALID), (k == FLEN_SPLIT) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/joy_split_demux.md
Name: joy_split_demux

Overview:
Front-end joystick stage that drives the DB9 splitter select line and demultiplexes the shared JOYSTICK bus into two player ports. It feeds MODULO_PRINCIPAL's I_JOYSTICK_A/I_JOYSTICK_B. The block synchronises and debounces each sample, then ANDs in active-low keyboard overrides. It replaces the free-running per-clock toggle with a settled, time-sliced scan and also supports single-joystick mode.

Parameters:
SETTLE_CYCLES, 4, cycles JOY_SEL is held before a side is sampled; legal range 3..255
DEBOUNCE, 3, consecutive identical samples required before a debounced bit changes; legal range 1..15
JOY_W, 6, joystick bus width

Ports:
PCLK  in  1  system clock
I_RESET_N  in  1  asynchronous active-low reset
JOYSTICK  in  JOY_W  shared joystick lines, active-low, asynchronous to PCLK
KEY_JOY_A  in  JOY_W  keyboard-emulated player A controls, active-low
KEY_JOY_B  in  JOY_W  keyboard-emulated player B controls, active-low
SPLIT_EN  in  1  1 = two joysticks via splitter; 0 = single joystick
JOY_SEL  out  1  splitter select: 0 = side A, 1 = side B
JOY_A  out  JOY_W  player A, active-low, registered
JOY_B  out  JOY_W  player B, active-low, registered
VALID  out  1  one-cycle pulse marking completion of a scan frame

Behaviour:
- Clock and reset: one clock, PCLK. Reset is asynchronous and active-low on I_RESET_N.
- Reset values: JOY_SEL=0, JOY_A=JOY_B={JOY_W{1}}, VALID=0, state=SETTLE_A, settle counter=0, debounce counters=0, debounced regs=all 1, synchroniser flops=all 1.
- Input sync: JOYSTICK passes through a 2-flop synchroniser. All samples are taken from the second flop.
- FSM states:
  - SETTLE_A: JOY_SEL=0; counter increments; at counter==SETTLE_CYCLES-1, counter clears and next state is SAMPLE_A.
  - SAMPLE_A: capture the synced sample into side-A debounce. Next state is SETTLE_B if SPLIT_EN=1, else SETTLE_A.
  - SETTLE_B: JOY_SEL=1; same counting rule; next state is SAMPLE_B.
  - SAMPLE_B: capture into side-B debounce; next state is SETTLE_A.
- JOY_SEL is a register. It changes on the clock edge entering SETTLE_A/SETTLE_B, never mid-settle.
- Frame length: split mode 2*(SETTLE_CYCLES+1) cycles; single mode SETTLE_CYCLES+1 cycles.
- Debounce, per bit and per side:
  - A 4-bit counter tracks consecutive samples that differ from the current debounced value.
  - A sample equal to the debounced value clears the counter.
  - When the counter would reach DEBOUNCE, the debounced bit flips and the counter clears.
  - DEBOUNCE=1 means the bit follows every sample.
- Outputs:
  - JOY_A = debA & KEY_JOY_A, registered, updated every cycle.
  - JOY_B = debB & KEY_JOY_B in split mode. In single mode JOY_B = KEY_JOY_B and debB is held at all 1.
  - A debounced change appears on JOY_x 2 cycles after the SAMPLE state edge: one cycle for the debounce reg, one for the output reg.
  - Key overrides reach the output with 1-cycle latency, independent of the scan.
- VALID: asserted for exactly one cycle, the cycle after SAMPLE_B in split mode, or after SAMPLE_A in single mode.
- SPLIT_EN toggles mid-frame:
  - The new value is sampled only at SAMPLE_A, so the current frame always completes.
  - A 1→0 change takes effect at the next SAMPLE_A. From then on debB is forced to all 1 and its counters clear.
- Reset mid-frame: immediate return to reset values. No partial update or VALID pulse is emitted after reset release. The first VALID comes one full frame after release.
- Simultaneous event: a key override and a joystick press on the same bit give active-low (pressed) output. AND semantics apply, with no priority logic.

Test Plan:
1. Reset release, SPLIT_EN=1, JOYSTICK=3F, defaults → JOY_SEL sequence over 10-cycle frames: 0 for 5 cycles, 1 for 5 cycles. VALID pulses every 10 cycles, first at cycle 10. JOY_A=JOY_B=3F throughout.
2. Side A drives 3E when JOY_SEL=0, side B drives 37 when JOY_SEL=1 (splitter model) → after 3 frames (DEBOUNCE=3), JOY_A=3E and JOY_B=37. Neither changes after only 2 frames.
3. Glitch: bit0 low on side A for exactly 2 SAMPLE_A events, then high → JOY_A stays 3F. The counter clears on the third (high) sample.
4. SPLIT_EN=0 with JOYSTICK=3B, KEY_JOY_B=1F → JOY_SEL held 0, frame length 5 cycles, JOY_A=3B after 3 frames, JOY_B=1F, VALID every 5 cycles.
5. KEY_JOY_A=2F with joystick idle → JOY_A=2F exactly 1 cycle later. Then JOYSTICK side A=3E debounced → JOY_A=2E.
6. Assert I_RESET_N low during SETTLE_B with JOY_A=3E → outputs return to 3F asynchronously, JOY_SEL=0, VALID=0. After release there is no VALID for 10 cycles.
